// File: rtl/dbus_sram_responder_if.sv
// Commit-stage data bus: request from the commit stage, response back from the memory side.
// Handshake: a request is taken in any cycle where req and addr_ok are both 1; data_ok is a one-cycle pulse with no backpressure.
interface dbus_sram_responder_if;
    typedef struct packed {
        logic        req;
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  write_en;
        logic [1:0]  size;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    dbus_req_t  dmem_req;
    dbus_resp_t dmem_resp;

    modport master (output dmem_req, input dmem_resp);
    modport slave  (input dmem_req, output dmem_resp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus slave backed by a synchronous SRAM port: in-order responses after MEM_LATENCY+1 cycles,
// with a bounded number of outstanding requests, protocol checking and completion counters.
module dbus_sram_responder #(
    parameter int IDX_WIDTH       = 14,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_sram_responder_if.slave dmem,
    output logic                 sram_en,
    output logic [3:0]           sram_we,
    output logic [IDX_WIDTH-1:0] sram_idx,
    output logic [31:0]          sram_wdata,
    input  logic                 sram_gnt,
    input  logic [31:0]          sram_rdata,
    output logic                 proto_err,
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]          outstanding;
    logic [MEM_LATENCY-1:0] tag_v;
    logic [MEM_LATENCY-1:0] tag_w;
    logic                   resp_ok;
    logic                   resp_w;
    logic [31:0]            resp_data;
    logic                   accept;
    logic [2:0]             we_ones;
    logic [3:0]             we_need;
    logic                   bad_req;
    logic                   unused_addr_bits;

    assign accept = dmem.dmem_req.req & sram_gnt & (outstanding < MAX_OUT) & ~reset;

    assign sram_en    = accept;
    assign sram_we    = (accept & dmem.dmem_req.is_write) ? dmem.dmem_req.write_en : 4'b0;
    assign sram_idx   = dmem.dmem_req.addr[IDX_WIDTH+1:2];
    assign sram_wdata = dmem.dmem_req.data;

    assign dmem.dmem_resp = {accept, resp_ok, resp_data};

    assign unused_addr_bits = &{1'b0, dmem.dmem_req.addr[31:IDX_WIDTH+2]};

    // A write must enable exactly as many byte lanes as its size covers.
    assign we_ones = {2'b0, dmem.dmem_req.write_en[0]} + {2'b0, dmem.dmem_req.write_en[1]}
                   + {2'b0, dmem.dmem_req.write_en[2]} + {2'b0, dmem.dmem_req.write_en[3]};
    assign we_need = 4'd1 << dmem.dmem_req.size;

    always_comb begin
        bad_req = 1'b0;
        if (dmem.dmem_req.is_write && dmem.dmem_req.write_en == 4'b0)
            bad_req = 1'b1;
        if (dmem.dmem_req.size == 2'd2 && dmem.dmem_req.addr[1:0] != 2'b00)
            bad_req = 1'b1;
        if (dmem.dmem_req.size == 2'd1 && dmem.dmem_req.addr[0] != 1'b0)
            bad_req = 1'b1;
        if (dmem.dmem_req.is_write && {1'b0, we_ones} != we_need)
            bad_req = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            tag_w <= '0;
        end else begin
            for (int i = MEM_LATENCY - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_w[i] <= tag_w[i-1];
            end
            tag_v[0] <= accept;
            tag_w[0] <= dmem.dmem_req.is_write;
        end
    end

    // The last tag stage lines up with the cycle sram_rdata is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_ok   <= 1'b0;
            resp_w    <= 1'b0;
            resp_data <= '0;
        end else begin
            resp_ok <= tag_v[MEM_LATENCY-1];
            if (tag_v[MEM_LATENCY-1]) begin
                resp_w    <= tag_w[MEM_LATENCY-1];
                resp_data <= tag_w[MEM_LATENCY-1] ? 32'h0 : sram_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, resp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            if (accept && bad_req)
                proto_err <= 1'b1;
            if (resp_ok && resp_w)
                wr_cnt <= wr_cnt + 32'd1;
            if (resp_ok && !resp_w)
                rd_cnt <= rd_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: one instance at MEM_LATENCY=1 and one at MEM_LATENCY=2,
// each with a behavioural write-first SRAM and a scoreboard of expected responses.
module tb_dbus_sram_responder;
  logic clk = 1'b0;
  logic reset;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_sram_responder_if a_bus ();
  dbus_sram_responder_if b_bus ();

  logic a_en, b_en, a_gnt, b_gnt, a_perr, b_perr;
  logic [3:0] a_we, b_we;
  logic [13:0] a_idx, b_idx;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, b_p1;
  logic [31:0] a_rd, a_wr, b_rd, b_wr;

  dbus_sram_responder #(.IDX_WIDTH(14), .MEM_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut_a (
    .clk(clk), .reset(reset), .dmem(a_bus.slave),
    .sram_en(a_en), .sram_we(a_we), .sram_idx(a_idx), .sram_wdata(a_wdata),
    .sram_gnt(a_gnt), .sram_rdata(a_rdata), .proto_err(a_perr), .rd_cnt(a_rd), .wr_cnt(a_wr)
  );

  dbus_sram_responder #(.IDX_WIDTH(14), .MEM_LATENCY(2), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk(clk), .reset(reset), .dmem(b_bus.slave),
    .sram_en(b_en), .sram_we(b_we), .sram_idx(b_idx), .sram_wdata(b_wdata),
    .sram_gnt(b_gnt), .sram_rdata(b_rdata), .proto_err(b_perr), .rd_cnt(b_rd), .wr_cnt(b_wr)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAMs: write-first, read data valid MEM_LATENCY cycles after the access.
  logic [31:0] sram_a [256];
  logic [31:0] sram_b [256];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) sram_a[i] <= '0;
      a_rdata <= '0;
    end else if (a_en) begin
      sram_a[a_idx[7:0]] <= merge(sram_a[a_idx[7:0]], a_wdata, a_we);
      a_rdata <= merge(sram_a[a_idx[7:0]], a_wdata, a_we);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) sram_b[i] <= '0;
      b_p1 <= '0;
      b_rdata <= '0;
    end else begin
      if (b_en) begin
        sram_b[b_idx[7:0]] <= merge(sram_b[b_idx[7:0]], b_wdata, b_we);
        b_p1 <= merge(sram_b[b_idx[7:0]], b_wdata, b_we);
      end
      b_rdata <= b_p1;
    end
  end

  // Reference memory images and scoreboard queues.
  logic [31:0] mdl_a [256];
  logic [31:0] mdl_b [256];
  logic [31:0] exp_a_q[$];
  int exp_a_cyc_q[$];
  logic [31:0] exp_b_q[$];
  int exp_b_cyc_q[$];

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
  endtask

  task automatic push_a(input logic w, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    if (w) begin
      mdl_a[addr[9:2]] = merge(mdl_a[addr[9:2]], data, we);
      exp_a_q.push_back(32'h0);
    end else begin
      exp_a_q.push_back(mdl_a[addr[9:2]]);
    end
    exp_a_cyc_q.push_back(cyc + 2);
  endtask

  task automatic push_b(input logic w, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    if (w) begin
      mdl_b[addr[9:2]] = merge(mdl_b[addr[9:2]], data, we);
      exp_b_q.push_back(32'h0);
    end else begin
      exp_b_q.push_back(mdl_b[addr[9:2]]);
    end
    exp_b_cyc_q.push_back(cyc + 3);
  endtask

  task automatic set_a_req(input logic w, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] we, input logic [1:0] sz);
    a_bus.dmem_req.req = 1'b1;
    a_bus.dmem_req.is_write = w;
    a_bus.dmem_req.addr = addr;
    a_bus.dmem_req.data = data;
    a_bus.dmem_req.write_en = we;
    a_bus.dmem_req.size = sz;
  endtask

  task automatic set_b_req(input logic w, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] we, input logic [1:0] sz);
    b_bus.dmem_req.req = 1'b1;
    b_bus.dmem_req.is_write = w;
    b_bus.dmem_req.addr = addr;
    b_bus.dmem_req.data = data;
    b_bus.dmem_req.write_en = we;
    b_bus.dmem_req.size = sz;
  endtask

  // Drivers: hold the request until addr_ok, then drop req one edge later.
  task automatic a_issue(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] we, input logic [1:0] sz, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    set_a_req(w, addr, data, we, sz);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (a_bus.dmem_resp.addr_ok === 1'b1) begin
        got = 1;
        acc_cyc = cyc;
        push_a(w, addr, data, we);
      end else begin
        @(posedge clk);
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL a_issue_timeout addr=%h addr_ok never seen, required within 50 cycles", addr);
    end else begin
      @(posedge clk);
    end
    #1 a_bus.dmem_req.req = 1'b0;
  endtask

  task automatic b_issue(input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] we, input logic [1:0] sz, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    set_b_req(w, addr, data, we, sz);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (b_bus.dmem_resp.addr_ok === 1'b1) begin
        got = 1;
        acc_cyc = cyc;
        push_b(w, addr, data, we);
      end else begin
        @(posedge clk);
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL b_issue_timeout addr=%h addr_ok never seen, required within 50 cycles", addr);
    end else begin
      @(posedge clk);
    end
    #1 b_bus.dmem_req.req = 1'b0;
  endtask

  task automatic monitor_a();
    logic [31:0] e;
    int ec;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && a_bus.dmem_resp.data_ok !== 1'b0) begin
        n_vec++;
        if (exp_a_q.size() == 0) begin
          n_err++;
          $display("FAIL a_unexpected_data_ok data_ok=%b cyc=%0d, required no response", a_bus.dmem_resp.data_ok, cyc);
        end else begin
          e = exp_a_q.pop_front();
          ec = exp_a_cyc_q.pop_front();
          if (a_bus.dmem_resp.data !== e || cyc != ec) begin
            n_err++;
            $display("FAIL a_resp data=%h cyc=%0d, required data=%h cyc=%0d", a_bus.dmem_resp.data, cyc, e, ec);
          end
        end
      end
    end
  endtask

  task automatic monitor_b();
    logic [31:0] e;
    int ec;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && b_bus.dmem_resp.data_ok !== 1'b0) begin
        n_vec++;
        if (exp_b_q.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected_data_ok data_ok=%b cyc=%0d, required no response", b_bus.dmem_resp.data_ok, cyc);
        end else begin
          e = exp_b_q.pop_front();
          ec = exp_b_cyc_q.pop_front();
          if (b_bus.dmem_resp.data !== e || cyc != ec) begin
            n_err++;
            $display("FAIL b_resp data=%h cyc=%0d, required data=%h cyc=%0d", b_bus.dmem_resp.data, cyc, e, ec);
          end
        end
      end
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && i < 40) begin
      @(posedge clk);
      i++;
    end
    n_vec++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending a=%0d b=%0d, required 0 0", exp_a_q.size(), exp_b_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_gnt = 1'b1;
    b_gnt = 1'b1;
    set_a_req(1'b1, 32'h10, 32'h1234_5678, 4'hF, 2'd2);
    set_b_req(1'b0, 32'h0, 32'h0, 4'h0, 2'd2);
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (a_bus.dmem_resp.addr_ok !== 1'b0 || a_en !== 1'b0 || a_we !== 4'h0) begin
      n_err++;
      $display("FAIL reset_gating addr_ok=%b en=%b we=%h, required 0 0 0", a_bus.dmem_resp.addr_ok, a_en, a_we);
    end
    n_vec++;
    if (b_bus.dmem_resp.addr_ok !== 1'b0 || b_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_gating_b addr_ok=%b en=%b, required 0 0", b_bus.dmem_resp.addr_ok, b_en);
    end
    a_bus.dmem_req.req = 1'b0;
    b_bus.dmem_req.req = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (a_bus.dmem_resp.data_ok !== 1'b0 || a_bus.dmem_resp.data !== 32'h0 || a_perr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_resp data_ok=%b data=%h proto_err=%b, required 0 0 0",
               a_bus.dmem_resp.data_ok, a_bus.dmem_resp.data, a_perr);
    end
    n_vec++;
    if (a_rd !== 32'd0 || a_wr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters rd=%0d wr=%0d, required 0 0", a_rd, a_wr);
    end
  endtask

  task automatic test_write_read();
    int rc, ac;
    rc = cyc;
    a_issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'd2, ac);
    n_vec++;
    if (ac != rc) begin
      n_err++;
      $display("FAIL wr_addr_ok_cycle accept=%0d, required %0d", ac, rc);
    end
    a_issue(1'b0, 32'h10, 32'h0, 4'h0, 2'd2, ac);
    drain();
    n_vec++;
    if (a_wr !== 32'd1 || a_rd !== 32'd1) begin
      n_err++;
      $display("FAIL wr_rd_counts wr=%0d rd=%0d, required 1 1", a_wr, a_rd);
    end
  endtask

  task automatic test_byte_write();
    int ac;
    a_issue(1'b1, 32'h10, 32'h1122_3344, 4'hF, 2'd2, ac);
    a_issue(1'b1, 32'h13, 32'hAA00_0000, 4'h8, 2'd0, ac);
    a_issue(1'b0, 32'h10, 32'h0, 4'h0, 2'd2, ac);
    drain();
    n_vec++;
    if (a_perr !== 1'b0) begin
      n_err++;
      $display("FAIL byte_proto_err proto_err=%b, required 0", a_perr);
    end
    n_vec++;
    if (a_wr !== 32'd3 || a_rd !== 32'd2) begin
      n_err++;
      $display("FAIL byte_counts wr=%0d rd=%0d, required 3 2", a_wr, a_rd);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2;
    b_issue(1'b1, 32'h0, 32'hA000_0000, 4'hF, 2'd2, c0);
    b_issue(1'b1, 32'h4, 32'hA000_0004, 4'hF, 2'd2, c1);
    b_issue(1'b1, 32'h8, 32'hA000_0008, 4'hF, 2'd2, c2);
    drain();
    b_issue(1'b0, 32'h0, 32'h0, 4'h0, 2'd2, c0);
    b_issue(1'b0, 32'h4, 32'h0, 4'h0, 2'd2, c1);
    b_issue(1'b0, 32'h8, 32'h0, 4'h0, 2'd2, c2);
    n_vec++;
    if (c1 != c0 + 1) begin
      n_err++;
      $display("FAIL b2b_second_accept cycle=%0d, required %0d", c1, c0 + 1);
    end
    // First data_ok is at c0+3; the freed slot is usable the cycle after.
    n_vec++;
    if (c2 != c0 + 4) begin
      n_err++;
      $display("FAIL b2b_third_accept cycle=%0d, required %0d", c2, c0 + 4);
    end
    drain();
    n_vec++;
    if (b_rd !== 32'd3 || b_wr !== 32'd3) begin
      n_err++;
      $display("FAIL b2b_counts rd=%0d wr=%0d, required 3 3", b_rd, b_wr);
    end
  endtask

  task automatic test_grant_stall();
    int ac;
    a_issue(1'b0, 32'h10, 32'h0, 4'h0, 2'd2, ac);
    a_gnt = 1'b0;
    set_a_req(1'b0, 32'h14, 32'h0, 4'h0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (a_bus.dmem_resp.addr_ok !== 1'b0 || a_en !== 1'b0) begin
        n_err++;
        $display("FAIL gnt_stall_%0d addr_ok=%b en=%b, required 0 0", i, a_bus.dmem_resp.addr_ok, a_en);
      end
      @(posedge clk);
      #1;
    end
    a_gnt = 1'b1;
    @(negedge clk);
    n_vec++;
    if (a_bus.dmem_resp.addr_ok !== 1'b1 || a_en !== 1'b1) begin
      n_err++;
      $display("FAIL gnt_rise_accept addr_ok=%b en=%b, required 1 1", a_bus.dmem_resp.addr_ok, a_en);
    end else begin
      push_a(1'b0, 32'h14, 32'h0, 4'h0);
    end
    @(posedge clk);
    #1 a_bus.dmem_req.req = 1'b0;
    drain();
  endtask

  task automatic test_proto_err();
    set_a_req(1'b0, 32'h6, 32'h0, 4'h0, 2'd2);
    @(negedge clk);
    n_vec++;
    if (a_bus.dmem_resp.addr_ok !== 1'b1 || a_perr !== 1'b0) begin
      n_err++;
      $display("FAIL perr_accept addr_ok=%b proto_err=%b, required 1 0", a_bus.dmem_resp.addr_ok, a_perr);
    end
    if (a_bus.dmem_resp.addr_ok === 1'b1) push_a(1'b0, 32'h6, 32'h0, 4'h0);
    @(posedge clk);
    #1 a_bus.dmem_req.req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_perr !== 1'b1) begin
      n_err++;
      $display("FAIL perr_set proto_err=%b, required 1", a_perr);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (a_perr !== 1'b1) begin
      n_err++;
      $display("FAIL perr_sticky proto_err=%b, required 1", a_perr);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int ac;
    a_issue(1'b0, 32'h10, 32'h0, 4'h0, 2'd2, ac);
    a_issue(1'b0, 32'h14, 32'h0, 4'h0, 2'd2, ac);
    set_a_req(1'b0, 32'h18, 32'h0, 4'h0, 2'd2);
    reset = 1'b1;
    #1;
    n_vec++;
    if (a_bus.dmem_resp.data_ok !== 1'b0 || a_perr !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_resp data_ok=%b proto_err=%b, required 0 0", a_bus.dmem_resp.data_ok, a_perr);
    end
    n_vec++;
    if (a_rd !== 32'd0 || a_wr !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_counters rd=%0d wr=%0d, required 0 0", a_rd, a_wr);
    end
    n_vec++;
    if (a_bus.dmem_resp.addr_ok !== 1'b0 || a_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_gating addr_ok=%b en=%b, required 0 0", a_bus.dmem_resp.addr_ok, a_en);
    end
    exp_a_q.delete();
    exp_a_cyc_q.delete();
    exp_b_q.delete();
    exp_b_cyc_q.delete();
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    a_bus.dmem_req.req = 1'b0;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    a_issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 2'd2, ac);
    a_issue(1'b0, 32'h20, 32'h0, 4'h0, 2'd2, ac);
    drain();
    n_vec++;
    if (a_rd !== 32'd1 || a_wr !== 32'd1 || a_perr !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after rd=%0d wr=%0d proto_err=%b, required 1 1 0", a_rd, a_wr, a_perr);
    end
  endtask

  task automatic test_random_reads();
    int ac;
    logic [31:0] ad;
    for (int i = 0; i < 8; i++) begin
      ad = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        a_issue(1'b1, ad, $urandom, 4'hF, 2'd2, ac);
      else
        a_issue(1'b0, ad, 32'h0, 4'h0, 2'd2, ac);
    end
    drain();
  endtask

  initial begin
    a_bus.dmem_req = '0;
    b_bus.dmem_req = '0;
    fork
      monitor_a();
      monitor_b();
    join_none
    test_reset();
    test_write_read();
    test_byte_write();
    test_back_to_back();
    test_grant_stall();
    test_random_reads();
    test_proto_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Slave end of the data bus (dbus_req_t / dbus_resp_t) driven by the commit stage.
- Accepts requests with an addr_ok handshake and issues each to a synchronous, word-wide SRAM port.
- Returns read data or write completion with a single-cycle data_ok pulse, strictly in request order, after a fixed pipelined latency.
- Sits between the commit-stage data port and on-chip data RAM; replaces the cache/AXI path in the standalone test build.

Parameters:
- IDX_WIDTH, 14, SRAM word-index width; SRAM covers 2^IDX_WIDTH words, indexed by addr[IDX_WIDTH+1:2].
- MEM_LATENCY, 1, cycles from granted SRAM access to valid sram_rdata; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..MEM_LATENCY+1.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_req  in  dbus_req_t  fields req, is_write, addr[31:0], data[31:0], write_en[3:0], size[1:0].
- dmem_resp  out  dbus_resp_t  fields addr_ok, data_ok, data[31:0].
- sram_en  out  1  SRAM access strobe.
- sram_we  out  4  SRAM byte write enables.
- sram_idx  out  IDX_WIDTH  SRAM word index.
- sram_wdata  out  32  SRAM write data.
- sram_gnt  in  1  SRAM can take an access this cycle; 0 means a refresh or arbitration loss.
- sram_rdata  in  32  SRAM read data, valid MEM_LATENCY cycles after a granted access.
- proto_err  out  1  sticky protocol-violation flag.
- rd_cnt  out  32  count of completed reads.
- wr_cnt  out  32  count of completed writes.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears the tag pipeline, outstanding count, proto_err, rd_cnt, wr_cnt and the registered response.
  - data_ok=0, data=0.
  - addr_ok, sram_en and sram_we are forced to 0 while reset is high.
  - In-flight requests are dropped and never answered.
- Accept condition (combinational):
  - accept = req & sram_gnt & (outstanding < MAX_OUTSTANDING).
  - addr_ok = accept.
- Same cycle as an accept:
  - sram_en=1, sram_idx=addr[IDX_WIDTH+1:2], sram_wdata=data.
  - sram_we = is_write ? write_en : 4'b0.
  - Otherwise sram_en=0 and sram_we=0.
- Tag pipeline:
  - MEM_LATENCY stages of {valid, is_write}.
  - Stage 0 loads {accept, is_write} each cycle; every stage shifts every cycle.
  - There is no backpressure: the requester always consumes data_ok.
- Response:
  - When the last stage is valid, the response register loads data_ok=1 and data = is_write ? 0 : sram_rdata. It is sampled in the cycle sram_rdata is valid, then registered.
  - Total latency from the addr_ok cycle to the data_ok cycle is MEM_LATENCY+1.
  - data_ok is a one-cycle pulse.
  - data is not shifted or sign-extended; the requester extracts bytes using addr[1:0] and size.
- outstanding counter:
  - +1 on accept, −1 on data_ok; both in the same cycle leaves it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Ordering: responses are returned in accept order. A read after a write to the same word returns the new data, relying on SRAM write-first ordering; no forwarding is needed.
- Statistics: rd_cnt or wr_cnt increments on each data_ok according to the tag's is_write; both wrap at 2^32.
- proto_err is set on any accept where one of the following holds, and stays set until reset:
  - write with write_en==0;
  - size==2 and addr[1:0]!=0;
  - size==1 and addr[0]!=0;
  - write whose write_en popcount does not equal 1<<size.
  - The request is still performed.
- No back-to-back limit: with sram_gnt=1 and capacity available, one request is accepted per cycle.
- sram_gnt=0: addr_ok=0. Responses already in flight still complete on schedule.
- If req drops before addr_ok, nothing is issued; the requester must hold the request stable until addr_ok.

Test Plan:
- Write then read, MEM_LATENCY=1:
  - Stimulus: write addr=0x00000010 data=0xDEADBEEF write_en=4'hF size=2, then a read of the same address.
  - Required: addr_ok in the request cycle; data_ok 2 cycles later for each; read data=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
- Byte write:
  - Stimulus: byte write addr=0x13 data=0xAA000000 write_en=4'h8 size=0 over a word holding 0x11223344, then read addr=0x10.
  - Required: read returns 0xAA223344; proto_err=0.
- Back-to-back and capacity:
  - Stimulus: MAX_OUTSTANDING=2, MEM_LATENCY=2, continuous reads of 0x0, 0x4, 0x8.
  - Required: third addr_ok is delayed until the first data_ok; responses return in order.
- Grant stall:
  - Stimulus: hold sram_gnt=0 for 3 cycles with req=1.
  - Required: addr_ok=0 and sram_en=0 for those 3 cycles; accept in the cycle gnt rises; in-flight responses are unaffected.
- Protocol error:
  - Stimulus: word read at addr=0x6.
  - Required: proto_err=1 from the next cycle and stays set; the access still completes with data_ok.
- Reset mid-operation:
  - Stimulus: assert reset with 2 requests outstanding.
  - Required: data_ok, proto_err and the counters immediately go to 0; no late data_ok after release; a new request after release is answered normally.
